// File: rtl/shift_capture.sv
// Serial-to-parallel frame capture: LSB-first bursts of exactly WIDTH bits are
// assembled in a right-shift register and handed to a one-word holding register.
module shift_capture #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Shift_En,
  input  logic             Serial_In,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Data_Valid,
  output logic             Frame_Err,
  output logic             Overrun,
  output logic             Busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] shreg;
  logic             offer;
  logic             transfer;

  // A good frame ends on the first low strobe after exactly WIDTH samples.
  assign offer    = (state == SHIFT) && !Shift_En && (count == FULL_CNT);
  assign transfer = Data_Valid && Out_Ready;
  assign Busy     = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      Frame_Err <= 1'b0;
    end else begin
      Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (Shift_En) begin
            shreg <= {Serial_In, shreg[WIDTH-1:1]};
            count <= CNT_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (Shift_En) begin
            if (count == FULL_CNT) begin
              Frame_Err <= 1'b1;
              state     <= DRAIN;
            end else begin
              shreg <= {Serial_In, shreg[WIDTH-1:1]};
              count <= count + CNT_W'(1);
            end
          end else begin
            Frame_Err <= (count != FULL_CNT);
            count     <= '0;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          if (!Shift_En) begin
            count <= '0;
            state <= IDLE;
          end
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Holding register runs independently; a transfer frees the slot in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      Overrun <= 1'b0;
      if (offer) begin
        if (!Data_Valid || transfer) begin
          Data_Out   <= shreg;
          Data_Valid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (transfer) begin
        Data_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_capture.sv
// Bench for shift_capture: directed scenarios plus randomized bursts against a
// burst-length based reference model.
module tb_shift_capture;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Shift_En = 1'b0;
  logic         Serial_In = 1'b0;
  logic         Out_Ready = 1'b0;
  logic [W-1:0] Data_Out;
  logic         Data_Valid;
  logic         Frame_Err;
  logic         Overrun;
  logic         Busy;

  int checks = 0;
  int failures = 0;

  shift_capture #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Shift_En   (Shift_En),
    .Serial_In  (Serial_In),
    .Out_Ready  (Out_Ready),
    .Data_Out   (Data_Out),
    .Data_Valid (Data_Valid),
    .Frame_Err  (Frame_Err),
    .Overrun    (Overrun),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // Reference model: burst length so far, bits placed by position, one-slot store.
  int           m_len = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_hold = '0;
  logic         m_valid = 1'b0;
  logic         m_ferr = 1'b0;
  logic         m_ovr = 1'b0;

  task automatic model_step(input logic se, input logic si, input logic rdy, input logic rst);
    logic offer;
    logic xfer;
    offer  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (rst) begin
      m_len   = 0;
      m_word  = '0;
      m_hold  = '0;
      m_valid = 1'b0;
      return;
    end
    if (se) begin
      if (m_len < W) m_word[m_len] = si;
      if (m_len == W) m_ferr = 1'b1;
      m_len++;
    end else begin
      if (m_len == W) offer = 1'b1;
      else if (m_len > 0 && m_len < W) m_ferr = 1'b1;
      m_len = 0;
    end
    xfer = m_valid && rdy;
    if (offer) begin
      if (!m_valid || xfer) begin
        m_hold  = m_word;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick(input logic se, input logic si, input logic rdy, input logic rst);
    Shift_En  = se;
    Serial_In = si;
    Out_Ready = rdy;
    Reset     = rst;
    @(posedge Clk);
    model_step(se, si, rdy, rst);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] word, input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b1, word[i % W], rdy, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (Data_Out !== 8'h00 || Data_Valid !== 1'b0 || Frame_Err !== 1'b0 ||
        Overrun !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got out=%h v=%b fe=%b ov=%b busy=%b, want all 0",
               Data_Out, Data_Valid, Frame_Err, Overrun, Busy);
    end
  endtask

  task automatic test_good_frame();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'hA5, W, 1'b0);
    checks++;
    if (Busy !== 1'b1 || Data_Valid !== 1'b0) begin
      failures++;
      $display("FAIL good_busy: got busy=%b v=%b, want busy=1 v=0", Busy, Data_Valid);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Data_Valid !== 1'b1 || Data_Out !== 8'hA5 || Frame_Err !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL good_frame: got v=%b out=%h fe=%b busy=%b, want v=1 out=a5 fe=0 busy=0",
               Data_Valid, Data_Out, Frame_Err, Busy);
    end
  endtask

  task automatic test_short_burst();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'h1F, 5, 1'b0);
    checks++;
    if (Frame_Err !== 1'b0) begin
      failures++;
      $display("FAIL short_early_err: got fe=%b want 0", Frame_Err);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Frame_Err !== 1'b1 || Data_Valid !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL short_err: got fe=%b v=%b busy=%b, want fe=1 v=0 busy=0",
               Frame_Err, Data_Valid, Busy);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Frame_Err !== 1'b0) begin
      failures++;
      $display("FAIL short_pulse_len: got fe=%b want 0", Frame_Err);
    end
  endtask

  task automatic test_long_burst();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'hFF, 8, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (Frame_Err !== 1'b1 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL long_err9: got fe=%b busy=%b, want fe=1 busy=1", Frame_Err, Busy);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Frame_Err !== 1'b0 || Busy !== 1'b1 || Data_Valid !== 1'b0) begin
      failures++;
      $display("FAIL long_drain10: got fe=%b busy=%b v=%b, want fe=0 busy=1 v=0",
               Frame_Err, Busy, Data_Valid);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Frame_Err !== 1'b0 || Busy !== 1'b0 || Data_Valid !== 1'b0) begin
      failures++;
      $display("FAIL long_end: got fe=%b busy=%b v=%b, want 0 0 0", Frame_Err, Busy, Data_Valid);
    end
    send_bits(8'h5A, W, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Data_Valid !== 1'b1 || Data_Out !== 8'h5A || Frame_Err !== 1'b0) begin
      failures++;
      $display("FAIL long_then_good: got v=%b out=%h fe=%b, want v=1 out=5a fe=0",
               Data_Valid, Data_Out, Frame_Err);
    end
  endtask

  task automatic test_backpressure();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'h3C, W, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'hC3, W, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Overrun !== 1'b1 || Data_Out !== 8'h3C || Data_Valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_overrun: got ov=%b out=%h v=%b, want ov=1 out=3c v=1",
               Overrun, Data_Out, Data_Valid);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Overrun !== 1'b0 || Data_Out !== 8'h3C) begin
      failures++;
      $display("FAIL bp_hold: got ov=%b out=%h, want ov=0 out=3c", Overrun, Data_Out);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (Data_Valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got v=%b want 0", Data_Valid);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'hF0, W, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h0F, W, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (Data_Out !== 8'h0F || Data_Valid !== 1'b1 || Overrun !== 1'b0) begin
      failures++;
      $display("FAIL simul_xfer: got out=%h v=%b ov=%b, want out=0f v=1 ov=0",
               Data_Out, Data_Valid, Overrun);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'h77, W, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'hFF, 4, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Data_Out !== 8'h00 || Data_Valid !== 1'b0 || Frame_Err !== 1'b0 ||
        Overrun !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: got out=%h v=%b fe=%b ov=%b busy=%b, want all 0",
               Data_Out, Data_Valid, Frame_Err, Overrun, Busy);
    end
    send_bits(8'h81, W, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Data_Out !== 8'h81 || Data_Valid !== 1'b1 || Frame_Err !== 1'b0) begin
      failures++;
      $display("FAIL rst_then_frame: got out=%h v=%b fe=%b, want out=81 v=1 fe=0",
               Data_Out, Data_Valid, Frame_Err);
    end
  endtask

  task automatic test_random();
    int len;
    int gap;
    logic [W-1:0] w;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 250; b++) begin
      len = (($urandom % 3) == 0) ? int'($urandom_range(1, 11)) : W;
      gap = $urandom_range(1, 3);
      w   = W'($urandom);
      for (int i = 0; i < len + gap; i++) begin
        tick(i < len, w[i % W], 1'($urandom % 2), ($urandom % 97) == 0);
        checks++;
        if (Data_Valid !== m_valid || (m_valid && Data_Out !== m_hold) ||
            Frame_Err !== m_ferr || Overrun !== m_ovr || Busy !== (m_len > 0)) begin
          failures++;
          $display("FAIL rand_b%0d_c%0d: got v=%b out=%h fe=%b ov=%b busy=%b, want v=%b out=%h fe=%b ov=%b busy=%b",
                   b, i, Data_Valid, Data_Out, Frame_Err, Overrun, Busy,
                   m_valid, m_hold, m_ferr, m_ovr, (m_len > 0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_burst();
    test_long_burst();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_capture.md
SHIFT_CAPTURE -- requirements
Module: shift_capture

Interface
REQ-001 Parameter: WIDTH, default 8, serial frame length in bits (legal range 2..32).
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Shift_En  input  1  shift strobe; each high cycle carries one serial bit.
REQ-005 Serial_In  input  1  serial data bit, sampled only when Shift_En=1.
REQ-006 Out_Ready  input  1  consumer accepts held word when Data_Valid=1.
REQ-007 Data_Out  output  WIDTH  captured parallel word.
REQ-008 Data_Valid  output  1  Data_Out holds an unconsumed word.
REQ-009 Frame_Err  output  1  one-cycle pulse when a burst is not exactly WIDTH cycles.
REQ-010 Overrun  output  1  one-cycle pulse when a good frame is dropped because the holding register is full.
REQ-011 Busy  output  1  high whenever the capture FSM is not in IDLE.

Function
REQ-012 The block SHALL capture the serial bursts produced by the shift-register datapath: the first bit received is the word LSB.
REQ-013 Capture SHALL use a right-shift register: on every Shift_En=1 cycle, the register shifts right and Serial_In enters the MSB.
REQ-014 A bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL count the samples taken in the current burst.
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DRAIN.
REQ-016 IDLE with Shift_En=1: sample the bit, set count=1, go to SHIFT; IDLE with Shift_En=0: stay in IDLE.
REQ-017 SHIFT with Shift_En=1 and count<WIDTH: sample the bit, increment count, stay in SHIFT.
REQ-018 SHIFT with Shift_En=0 and count<WIDTH (short burst): pulse Frame_Err, discard the partial word, go to IDLE.
REQ-019 SHIFT with Shift_En=1 and count==WIDTH (long burst): pulse Frame_Err, sample nothing, go to DRAIN.
REQ-020 DRAIN: ignore Serial_In; stay in DRAIN while Shift_En=1, go to IDLE on the first Shift_En=0 cycle; no further Frame_Err pulses.
REQ-021 SHIFT with Shift_En=0 and count==WIDTH (good frame): go to IDLE and offer the word to the holding register in the same cycle.
REQ-022 The holding register (Data_Out plus a full flag driving Data_Valid) SHALL operate independently of the FSM.
REQ-023 A good frame offered while the register is empty SHALL be loaded; Data_Valid SHALL rise on the next edge, one cycle after the first Shift_En-low cycle.
REQ-024 Data_Valid=1 and Out_Ready=1 in the same cycle SHALL complete a transfer; Data_Valid clears on the next edge unless a good frame is offered in that cycle.
REQ-025 Good frame offered in the same cycle as a transfer: the new word SHALL be loaded, Data_Valid SHALL stay 1, and Overrun SHALL NOT pulse.
REQ-026 Good frame offered while full with Out_Ready=0: pulse Overrun, drop the new word, leave Data_Out unchanged.
REQ-027 Data_Out SHALL remain stable while Data_Valid=1 and no transfer has occurred.
REQ-028 Frame_Err and Overrun SHALL be registered outputs, high for exactly one cycle per event.

Reset
REQ-029 Reset=1 SHALL put the FSM in IDLE and clear count, the shift register, Data_Out (all 0), Data_Valid, Frame_Err, Overrun and Busy on the next edge.
REQ-030 Reset SHALL override all other inputs, including mid-burst, DRAIN, and a pending transfer.
REQ-031 After Reset is released, the first Shift_En=1 cycle SHALL be treated as bit 0 of a new frame.

Verification
REQ-032 Good frame (WIDTH=8): Shift_En high 8 cycles with Serial_In 1,0,1,0,0,1,0,1, then low -> Data_Valid=1 and Data_Out=0xA5 one cycle after Shift_En falls; Frame_Err=0.
REQ-033 Short burst: 5 Shift_En cycles then low -> single Frame_Err pulse on the Shift_En-low cycle, Data_Valid stays 0, Busy back to 0.
REQ-034 Long burst: 10 Shift_En cycles -> Frame_Err pulse on the 9th cycle, Busy held through the 10th cycle, no Data_Valid; a following good frame 0x5A is captured correctly.
REQ-035 Backpressure: frames 0x3C then 0xC3 with Out_Ready=0 -> Data_Out stays 0x3C, one Overrun pulse at the second completion; raising Out_Ready for one cycle clears Data_Valid.
REQ-036 Simultaneous events: frame 0x0F completes in the same cycle Out_Ready accepts held word 0xF0 -> Data_Out becomes 0x0F, Data_Valid stays 1, no Overrun.
REQ-037 Reset mid-operation: Reset asserted after 4 bits of a frame -> all outputs 0; the next full frame 0x81 yields Data_Out=0x81 with no Frame_Err.
